// File: rtl/gf180mcu_scan_chain_pkg.sv
// Shared types and sizing helpers for the gf180mcu scan-chain initiator.
// Optional compare logic in the top is enabled with SCAN_CMP_EN.
package gf180mcu_scan_chain_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_CAPTURE,
    S_UNLOAD
  } state_e;

  localparam int ERR_W_DEF = 16;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_scan_chain_shreg.sv
// Parallel-load, serial-in/serial-out shift register for the scan initiator.
// Load wins over shift; data moves towards the MSB, serial input at the LSB.
module gf180mcu_scan_chain_shreg #(
  parameter int N = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [N-1:0] i_d,
  input  logic         i_sin,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {r_q[N-2:0], i_sin};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gf180mcu_scan_chain_ctrl.sv
// Scan-chain initiator: load, single capture, overlapped unload, result port.
// Define SCAN_CMP_EN to build the expected-response compare and error counter.
module gf180mcu_scan_chain_ctrl
  import gf180mcu_scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int ERR_W     = ERR_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pat_valid,
  output logic                 o_pat_ready,
  input  logic [CHAIN_LEN-1:0] i_pat_data,
  input  logic [CHAIN_LEN-1:0] i_pat_exp,
  output logic                 o_se,
  output logic                 o_si,
  output logic                 o_chain_cke,
  input  logic                 i_so,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [CHAIN_LEN-1:0] o_res_data,
  output logic                 o_res_fail,
  output logic [ERR_W-1:0]     o_err_cnt,
  output logic                 o_busy
);

  localparam int N  = CHAIN_LEN;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic           r_have_resp;
  logic           r_from_load;
  logic [N-1:0]   w_q;
  logic [N-1:0]   w_post_data;
  logic           w_load;
  logic           w_shift;
  logic           w_post;
  logic           w_last;
  logic           w_accept;
  logic           w_fail;

  assign w_last   = (r_cnt == LAST);
  assign w_accept = i_pat_valid & o_pat_ready;

  assign o_pat_ready = ~i_rst &
    ((r_state == S_IDLE) | (r_state == S_CAPTURE));
  assign o_se = (r_state == S_LOAD) | (r_state == S_UNLOAD);
  assign o_si = (r_state == S_LOAD) & w_q[N-1];
  assign o_chain_cke = o_se | (r_state == S_CAPTURE);
  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_post      = 1'b0;
    w_post_data = {w_q[N-2:0], i_so};
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD, S_UNLOAD: begin
        w_shift = 1'b1;
        if (w_last) begin
          if (r_have_resp & o_res_valid & ~i_res_ready) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_post      = r_have_resp;
            w_state_nxt = (r_state == S_LOAD) ? S_CAPTURE : S_IDLE;
          end
        end
      end
      S_HOLD: begin
        w_post_data = w_q;
        if (i_res_ready) begin
          w_post      = 1'b1;
          w_state_nxt = r_from_load ? S_CAPTURE : S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_UNLOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  gf180mcu_scan_chain_shreg #(.N(N)) u_shreg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (i_pat_data),
    .i_sin   (i_so),
    .o_q     (w_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_have_resp <= 1'b0;
      r_from_load <= 1'b0;
    end else begin
      if (w_shift) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (r_state == S_IDLE && w_accept) r_have_resp <= 1'b0;
      else if (r_state == S_CAPTURE)     r_have_resp <= 1'b1;
      // Remember where to resume if this shift ends in HOLD.
      if (w_shift && w_last) r_from_load <= (r_state == S_LOAD);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
    end else if (w_post) begin
      o_res_valid <= 1'b1;
      o_res_data  <= w_post_data;
    end else if (i_res_ready) begin
      o_res_valid <= 1'b0;
    end
  end

`ifdef SCAN_CMP_EN
  logic [N-1:0]     r_exp_cur;
  logic [N-1:0]     r_exp_next;
  logic             r_res_fail;
  logic [ERR_W-1:0] r_err_cnt;

  assign w_fail = |(w_post_data ^ r_exp_cur);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exp_cur  <= '0;
      r_exp_next <= '0;
      r_res_fail <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_load) r_exp_next <= i_pat_exp;
      if (r_state == S_CAPTURE) r_exp_cur <= r_exp_next;
      if (w_post) begin
        r_res_fail <= w_fail;
        if (w_fail && r_err_cnt != {ERR_W{1'b1}})
          r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_res_fail = r_res_fail;
  assign o_err_cnt  = r_err_cnt;
`else
  logic w_unused_exp;

  assign w_fail       = 1'b0;
  assign w_unused_exp = ^{i_pat_exp, w_fail};
  assign o_res_fail   = 1'b0;
  assign o_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_gf180mcu_scan_chain_ctrl.sv
// Bench for gf180mcu_scan_chain_ctrl with a 4-flop behavioural scan chain.
// Expected fail/error values follow SCAN_CMP_EN as seen by this file.
module tb_gf180mcu_scan_chain_ctrl;

  localparam int N = 4;
  localparam logic [N-1:0] FUNC_D = 4'b0110;
`ifdef SCAN_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pat_valid = 1'b0;
  logic         pat_ready;
  logic [N-1:0] pat_data = '0;
  logic [N-1:0] pat_exp = '0;
  logic         se, si, cke;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] res_data;
  logic         res_fail;
  logic [15:0]  err_cnt;
  logic         busy;
  logic [N-1:0] chain = '0;
  logic         so;

  int n_chk = 0;
  int n_err = 0;
  int mcyc = 0;
  int run = 0;
  int last_run = 0;
  int m_err = 0;
  logic [N-1:0] pat_q[$];
  logic [N-1:0] exp_q[$];
  int stamp_q[$];

  always #5 clk = ~clk;

  gf180mcu_scan_chain_ctrl #(.CHAIN_LEN(N), .ERR_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pat_valid (pat_valid),
    .o_pat_ready (pat_ready),
    .i_pat_data  (pat_data),
    .i_pat_exp   (pat_exp),
    .o_se        (se),
    .o_si        (si),
    .o_chain_cke (cke),
    .i_so        (so),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_res_fail  (res_fail),
    .o_err_cnt   (err_cnt),
    .o_busy      (busy)
  );

  // Scan flops: position 0 fed by SI, functional D is a constant.
  always @(posedge clk)
    if (cke) chain <= se ? {chain[N-2:0], si} : FUNC_D;
  assign so = chain[N-1];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic [N-1:0] e);
    bit done = 1'b0;
    pat_valid = 1'b1;
    pat_data  = d;
    pat_exp   = e;
    for (int k = 0; k < 60 && !done; k++) begin
      done = pat_ready;
      tick();
    end
    pat_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_res();
    int k = 0;
    while (!res_valid && k < 40) begin
      tick();
      k++;
    end
    if (!res_valid) chk("res_timeout", 0, 1);
  endtask

  // Reference: every accepted pattern must appear in the chain at capture,
  // and every result reads FUNC_D with fail = (expected != FUNC_D).
  always @(negedge clk) begin
    logic [N-1:0] e;
    bit f;
    mcyc++;
    if (rst) begin
      pat_q.delete();
      exp_q.delete();
      m_err = 0;
    end else begin
      if (cke) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (pat_valid && pat_ready) begin
        pat_q.push_back(pat_data);
        exp_q.push_back(pat_exp);
      end
      if (cke && !se) begin
        if (pat_q.size() == 0) chk("cap_unexpected", 1, 0);
        else chk("cap_chain", chain, pat_q.pop_front());
      end
      if (res_valid && res_ready) begin
        stamp_q.push_back(mcyc);
        if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          f = CMP && (e != FUNC_D);
          if (f && m_err < 65535) m_err++;
          chk("res_data", res_data, FUNC_D);
          chk("res_fail", res_fail, f);
          chk("err_cnt", err_cnt, m_err);
        end
      end
    end
  end

  initial begin
    int sent;
    bit acc;
    bit seen;
    logic [N-1:0] c0;

    tick();
    tick();
    chk("rst_se", se, 0);
    chk("rst_si", si, 0);
    chk("rst_cke", cke, 0);
    chk("rst_rdy", pat_ready, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_rd", res_data, 0);
    chk("rst_rf", res_fail, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rdy_rel", pat_ready, 1);

    // Single pattern timing
    send(4'b1011, 4'b0110);
    for (int k = 1; k <= 10; k++) begin
      chk("t_se", se, (k <= 4) || (k >= 6 && k <= 9));
      chk("t_cke", cke, k <= 9);
      chk("t_rv", res_valid, k >= 10);
      if (k < 10) tick();
    end
    chk("t_rd", res_data, FUNC_D);
    chk("t_rf", res_fail, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Back-to-back streaming
    stamp_q.delete();
    res_ready = 1'b1;
    send(4'b1100, 4'b0110);
    send(4'b0011, 4'b0110);
    for (int k = 0; k < 30 && busy; k++) tick();
    tick();
    chk("bb_run", last_run, 14);
    chk("bb_nres", stamp_q.size(), 2);
    if (stamp_q.size() == 2) chk("bb_gap", stamp_q[1] - stamp_q[0], 5);
    res_ready = 1'b0;

    // Failing compare and error count
    send(4'b1100, 4'b0111);
    wait_res();
    chk("f1_fail", res_fail, CMP);
    chk("f1_err", err_cnt, CMP ? 1 : 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    send(4'b0101, 4'b0111);
    wait_res();
    chk("f2_err", err_cnt, CMP ? 2 : 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Back-pressure into HOLD
    send(4'b1110, 4'b0110);
    send(4'b0001, 4'b0110);
    for (int k = 0; k < 40 && !(busy && !cke); k++) tick();
    chk("h_enter", busy && !cke, 1);
    c0 = chain;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h_cke", cke, 0);
      chk("h_se", se, 0);
      chk("h_chain", chain, c0);
    end
    chk("h_rd1", res_data, FUNC_D);
    res_ready = 1'b1;
    tick();
    chk("h_rv2", res_valid, 1);
    chk("h_rd2", res_data, FUNC_D);
    chk("h_idle", busy, 0);
    tick();
    res_ready = 1'b0;

    // Reset during LOAD cycle 2
    send(4'b1001, 4'b0110);
    tick();
    rst = 1'b1;
    tick();
    chk("r_se", se, 0);
    chk("r_busy", busy, 0);
    chk("r_rv", res_valid, 0);
    chk("r_err", err_cnt, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen |= res_valid;
    end
    chk("r_nopost", seen, 0);

    // Randomised traffic with random back-pressure
    sent = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pat_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
        pat_valid = 1'b1;
        pat_data  = N'($urandom);
        pat_exp   = ($urandom_range(0, 1) == 1) ? FUNC_D : N'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      acc = pat_valid & pat_ready;
      tick();
      if (acc) begin
        pat_valid = 1'b0;
        sent++;
      end
      if (sent == 40 && exp_q.size() == 0 && !busy && !res_valid) break;
    end
    pat_valid = 1'b0;
    res_ready = 1'b0;
    chk("rnd_sent", sent, 40);
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_pats", pat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_scan_chain_ctrl.md
# gf180mcu_scan_chain_ctrl

Scan-chain initiator that drives a chain of scan flip-flops from the tester side. It accepts parallel stimulus patterns over a valid/ready port and serialises each one onto SI with SE high. It pulses a single capture cycle, unloads the chain response from SO overlapped with the next load, and returns the response plus a pass/fail verdict over a second valid/ready port. It sits between the on-chip test sequencer and the standard-cell scan chains, which share CLK.

## Interface
- CHAIN_LEN, 16: number of scan flops in the chain (≥2)
- ERR_W, 16: width of saturating error counter
- CLK  in  1  clock; chain flops clock on the same rising edge
- RST  in  1  reset, synchronous, active-high
- PAT_VALID  in  1  stimulus pattern offered
- PAT_READY  out  1  pattern accepted when PAT_VALID&PAT_READY
- PAT_DATA  in  CHAIN_LEN  stimulus; bit i lands in chain position i
- PAT_EXP  in  CHAIN_LEN  expected capture response for this pattern
- SE  out  1  scan enable to chain
- SI  out  1  serial data into chain position 0
- CHAIN_CKE  out  1  clock enable for chain clock gate
- SO  in  1  Q of chain position CHAIN_LEN-1
- RES_VALID  out  1  response available
- RES_READY  in  1  response consumed when RES_VALID&RES_READY
- RES_DATA  out  CHAIN_LEN  captured response; bit i from position i
- RES_FAIL  out  1  RES_DATA != expected
- ERR_CNT  out  ERR_W  saturating count of failing responses
- BUSY  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, HOLD, CAPTURE, UNLOAD.
- IDLE: PAT_READY=1, SE=0, CHAIN_CKE=0. On accept: latch PAT_DATA into shift register, PAT_EXP into exp_next, clear have_resp, go to LOAD.
- LOAD: SE=1, CHAIN_CKE=1, SI=shreg MSB, CHAIN_LEN cycles. Each edge shifts shreg left and inserts SO at LSB, so the first SO sample is position CHAIN_LEN-1. After CHAIN_LEN edges, shreg holds the prior response (valid only if have_resp).
- End of LOAD/UNLOAD: if have_resp and RES_VALID&!RES_READY, go to HOLD. Otherwise post the response (RES_DATA=shreg, RES_FAIL=|(shreg^exp_cur), RES_VALID=1, ERR_CNT+=fail, saturating) when have_resp. Then go to CAPTURE after LOAD, or to IDLE after UNLOAD.
- HOLD: SE=0, CHAIN_CKE=0; the chain is frozen. Leave HOLD on the cycle RES_READY is seen high, posting the response as above.
- CAPTURE: exactly one cycle, SE=0, CHAIN_CKE=1, PAT_READY=1. Set exp_cur←exp_next and have_resp←1.
  - If a pattern is accepted: reload shreg and exp_next, go to LOAD (overlapped unload).
  - Otherwise: go to UNLOAD.
- UNLOAD: as LOAD with SI=0.
- PAT_READY=0 in LOAD, HOLD, UNLOAD.
- RES_VALID stays high with stable data until the handshake completes.
- Bit counter runs 0..CHAIN_LEN-1 and wraps to 0 on each LOAD/UNLOAD exit.

## Timing
- Reset values: state IDLE, SE=0, SI=0, CHAIN_CKE=0, PAT_READY=0 while RST=1, RES_VALID=0, RES_DATA=0, RES_FAIL=0, ERR_CNT=0, BUSY=0.
- SE, SI and CHAIN_CKE are decoded from registered state/shreg only. They have no combinational path from any input.
- Single pattern accepted at edge t:
  - LOAD occupies cycles t+1..t+N.
  - CAPTURE occupies cycle t+N+1.
  - UNLOAD occupies cycles t+N+2..t+2N+1.
  - RES_VALID is high from cycle t+2N+2.
  - N=CHAIN_LEN.
- Streaming: one pattern per N+1 cycles with no idle cycles.
- RST mid-operation: the next cycle is IDLE. In-flight pattern and response are discarded. ERR_CNT clears.
- Simultaneous RES_READY and a new post at end of shift: the pending result is consumed and the new one posted the same edge, with no HOLD.

## Configuration
- SCAN_CMP_EN defined: exp_cur/exp_next registers, RES_FAIL and ERR_CNT are implemented as above.
- SCAN_CMP_EN undefined: PAT_EXP is ignored, no expected registers are built, and RES_FAIL and ERR_CNT are tied to 0.

## Structure
- Package gf180mcu_scan_chain_pkg holds:
  - the state enum
  - a function clog2-based counter width for CHAIN_LEN
  - the ERR_W default constant
- One sub-module, gf180mcu_scan_chain_shreg: a CHAIN_LEN-bit parallel-load, serial-in/serial-out shift register with load/shift enables.

## Test plan
Bench uses a 4-flop behavioural scan chain, CHAIN_LEN=4, functional D tied to 4'b0110, SCAN_CMP_EN defined.
- RST high 2 cycles, then low: all outputs at reset values, BUSY=0, PAT_READY=1 after release.
- PAT_DATA=4'b1011, PAT_EXP=4'b0110: SE high 4 cycles, one CAPTURE cycle with SE=0, then SE high 4 cycles. RES_VALID appears 10 cycles after accept with RES_DATA=0110 and RES_FAIL=0.
- Two patterns back-to-back, RES_READY=1: no UNLOAD between them. Two results 5 cycles apart. CHAIN_CKE stays continuously high for 14 cycles.
- PAT_EXP=4'b0111: RES_FAIL=1, ERR_CNT=1. A repeat gives ERR_CNT=2.
- RES_READY held low with two patterns queued: the second result enters HOLD with CHAIN_CKE=0 and chain contents unchanged. After RES_READY=1, the second RES_DATA is 0110.
- RST pulsed during LOAD cycle 2: the next cycle is IDLE, SE=0, RES_VALID=0, and no result is ever posted.
